// File: rtl/mulu_seq_pkg.sv
// Shared definitions for the digit-serial unsigned multiply sequencer:
// default widths, FSM state encoding and wrapper pin bit IDs.
package mulu_seq_pkg;

  localparam int DW_DEF  = 2;
  localparam int OPW_DEF = 4;
  localparam int ND_DEF  = OPW_DEF / DW_DEF;
  localparam int NS_DEF  = ND_DEF * ND_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  // Bit positions on the 8-pin wrapper I/O.
  localparam int PIN_X0    = 0;
  localparam int PIN_X1    = 1;
  localparam int PIN_Y0    = 2;
  localparam int PIN_Y1    = 3;
  localparam int PIN_START = 4;
  localparam int PIN_RDY   = 5;
  localparam int PIN_BUSY  = 6;
  localparam int PIN_PDAT  = 7;

  // Width of an index that spans n entries (never narrower than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mulu_seq_acc.sv
// Product accumulator: adds the core's partial product, shifted by DW*k,
// into a 2*OPW-bit register. sum is exposed so the final term can be
// folded straight into the product register on the last step.
module mulu_seq_acc
  import mulu_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF,
  parameter int KW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [2*DW-1:0]   mul_p,
  input  logic [KW-1:0]     k,
  output logic [2*OPW-1:0]  acc,
  output logic [2*OPW-1:0]  sum
);

  localparam int PW = 2 * OPW;

  logic [PW-1:0] term;

  always_comb begin
    term = PW'(mul_p) << (DW * int'(k));
    sum  = acc + term;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mulu_seq4.sv
// Sequencing controller: collects OPW-bit operands one digit per cycle,
// steps a shared DWxDW core over all digit pairs and registers the product.
module mulu_seq4
  import mulu_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DW-1:0]     x_in,
  input  logic [DW-1:0]     y_in,
  output logic [DW-1:0]     mul_x,
  output logic [DW-1:0]     mul_y,
  input  logic [2*DW-1:0]   mul_p,
  output logic [2*OPW-1:0]  p,
  output logic              busy,
  output logic              rdy
);

  localparam int ND = OPW / DW;
  localparam int IW = idx_w(ND);
  localparam int KW = IW + 1;

  state_t          state, state_nx;
  logic [IW-1:0]   count;
  logic [IW-1:0]   i_idx;
  logic [IW-1:0]   j_idx;
  logic [DW-1:0]   xdig [ND];
  logic [DW-1:0]   ydig [ND];

  logic            last_digit;
  logic            last_i;
  logic            last_step;
  logic            acc_clr;
  logic            acc_en;
  logic [KW-1:0]   k;
  logic [2*OPW-1:0] acc;
  logic [2*OPW-1:0] acc_sum;

  assign last_digit = (count == IW'(ND - 1));
  assign last_i     = (i_idx == IW'(ND - 1));
  assign last_step  = last_i && (j_idx == IW'(ND - 1));
  assign k          = KW'(i_idx) + KW'(j_idx);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_clr  = 1'b1;
          state_nx = (ND == 1) ? ST_MUL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_digit) state_nx = ST_MUL;
      end
      ST_MUL: begin
        acc_en = 1'b1;
        if (last_step) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Digit capture, step indices and the result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      i_idx <= '0;
      j_idx <= '0;
      p     <= '0;
      rdy   <= 1'b0;
      for (int n = 0; n < ND; n++) begin
        xdig[n] <= '0;
        ydig[n] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            xdig[0] <= x_in;
            ydig[0] <= y_in;
            count   <= IW'(1);
            i_idx   <= '0;
            j_idx   <= '0;
            rdy     <= 1'b0;
          end
        end
        ST_LOAD: begin
          xdig[count] <= x_in;
          ydig[count] <= y_in;
          count       <= count + IW'(1);
          if (last_digit) begin
            i_idx <= '0;
            j_idx <= '0;
          end
        end
        ST_MUL: begin
          if (last_i) begin
            i_idx <= '0;
            j_idx <= j_idx + IW'(1);
          end else begin
            i_idx <= i_idx + IW'(1);
          end
          if (last_step) begin
            p   <= acc_sum;
            rdy <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Core inputs stay at zero outside MUL so the shared multiplier is quiet.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (state == ST_MUL) begin
      mul_x = xdig[i_idx];
      mul_y = ydig[j_idx];
    end
  end

  mulu_seq_acc #(
    .DW  (DW),
    .OPW (OPW),
    .KW  (KW)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .mul_p (mul_p),
    .k     (k),
    .acc   (acc),
    .sum   (acc_sum)
  );

endmodule

// File: tb/tb_mulu_seq4.sv
// Directed and randomized checks of mulu_seq4 driving an ideal 2x2 core.
module tb_mulu_seq4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] x_in;
  logic [1:0] y_in;
  logic [1:0] mul_x;
  logic [1:0] mul_y;
  logic [3:0] mul_p;
  logic [7:0] p;
  logic       busy;
  logic       rdy;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] mseq_x [4];
  logic [1:0] mseq_y [4];

  mulu_seq4 #(.DW(2), .OPW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_p (mul_p),
    .p     (p),
    .busy  (busy),
    .rdy   (rdy)
  );

  assign mul_p = {2'b00, mul_x} * {2'b00, mul_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one operation starting at the current negedge; optionally pulses
  // start during LOAD and MUL. Returns p once rdy is seen.
  task automatic do_op(input logic [3:0] x, input logic [3:0] y, input bit pulse,
                       output logic [7:0] res);
    logic [7:0] p_old;
    int edges;
    bit seen;
    p_old = p;
    start = 1'b1;
    x_in  = x[1:0];
    y_in  = y[1:0];
    tick();
    edges = 1;
    start = pulse;
    x_in  = x[3:2];
    y_in  = y[3:2];
    chk("rdy_clr", {31'd0, rdy}, 32'd0);
    chk("busy_load", {31'd0, busy}, 32'd1);
    chk("mul_quiet_load", {28'd0, mul_x, mul_y}, 32'd0);
    seen = 1'b0;
    while (!seen && edges < 16) begin
      tick();
      edges++;
      start = pulse && (edges == 3);
      x_in  = 2'($urandom);
      y_in  = 2'($urandom);
      if (edges >= 2 && edges <= 5) begin
        mseq_x[edges-2] = mul_x;
        mseq_y[edges-2] = mul_y;
      end
      if (rdy) seen = 1'b1;
      else chk("p_hold", {24'd0, p}, {24'd0, p_old});
      chk("busy_rdy_excl", {31'd0, busy & rdy}, 32'd0);
    end
    start = 1'b0;
    chk("rdy_latency", edges, 6);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("mul_quiet_idle", {28'd0, mul_x, mul_y}, 32'd0);
    res = p;
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] rx, ry;
    reset = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;

    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'($urandom);
      x_in  = 2'($urandom);
      y_in  = 2'($urandom);
      #1;
      chk("rst_outputs", {20'd0, p, rdy, busy, mul_x, mul_y}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_outputs", {20'd0, p, rdy, busy, mul_x, mul_y}, 32'd0);
    end

    do_op(4'hB, 4'h6, 1'b0, r);
    chk("p_b_x_6", {24'd0, r}, 32'd66);
    chk("mseq0", {28'd0, mseq_x[0], mseq_y[0]}, {28'd0, 2'd3, 2'd2});
    chk("mseq1", {28'd0, mseq_x[1], mseq_y[1]}, {28'd0, 2'd2, 2'd2});
    chk("mseq2", {28'd0, mseq_x[2], mseq_y[2]}, {28'd0, 2'd3, 2'd1});
    chk("mseq3", {28'd0, mseq_x[3], mseq_y[3]}, {28'd0, 2'd2, 2'd1});

    do_op(4'hF, 4'hF, 1'b0, r);
    chk("p_f_x_f", {24'd0, r}, 32'd225);
    do_op(4'h0, 4'h9, 1'b0, r);
    chk("p_0_x_9", {24'd0, r}, 32'd0);
    do_op(4'h1, 4'h1, 1'b0, r);
    chk("p_1_x_1", {24'd0, r}, 32'd1);

    do_op(4'hB, 4'h6, 1'b1, r);
    chk("p_start_ignored", {24'd0, r}, 32'd66);
    do_op(4'hF, 4'hF, 1'b0, r);
    chk("p_back_to_back", {24'd0, r}, 32'd225);

    // Abort during the third MUL step.
    start = 1'b1; x_in = 2'd3; y_in = 2'd2;
    tick();
    start = 1'b0; x_in = 2'd2; y_in = 2'd1;
    tick();
    tick();
    tick();
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", {20'd0, p, rdy, busy, mul_x, mul_y}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_abort_idle", {20'd0, p, rdy, busy, mul_x, mul_y}, 32'd0);
    do_op(4'h7, 4'h3, 1'b0, r);
    chk("p_7_x_3", {24'd0, r}, 32'd21);

    for (int t = 0; t < 200; t++) begin
      rx = 4'($urandom);
      ry = 4'($urandom);
      do_op(rx, ry, 1'($urandom), r);
      chk("p_rand", {24'd0, r}, {24'd0, 8'(rx) * 8'(ry)});
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
